wb_regfile: RTL

- Consumer end of the execute-stage result interface.
- Latches each EX result (write address, write enable, write data) through EX/MEM and MEM/WB pipeline registers.
- Commits the result to a 32-entry general register file.
- Serves the decode stage's two read ports, forwarding from in-flight EX, MEM and WB results so no read returns stale data.

---
 rtl/wb_regfile_if.sv | 43 ++++
 rtl/wb_regfile.sv | 91 +++++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: EX result in, pipeline stage taps out, two decode read ports.
interface wb_regfile_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          stall_i;
    logic          flush_i;
    logic [AW-1:0] ex_waddr_i;
    logic          ex_wreg_i;
    logic [DW-1:0] ex_wdata_i;
    logic          re1_i;
    logic [AW-1:0] raddr1_i;
    logic [DW-1:0] rdata1_o;
    logic          re2_i;
    logic [AW-1:0] raddr2_i;
    logic [DW-1:0] rdata2_o;
    logic [AW-1:0] mem_waddr_o;
    logic          mem_wreg_o;
    logic [DW-1:0] mem_wdata_o;
    logic [AW-1:0] wb_waddr_o;
    logic          wb_wreg_o;
    logic [DW-1:0] wb_wdata_o;

    // Pipeline control, EX producer and decode reader side
    modport master (
        output stall_i, flush_i,
        output ex_waddr_i, ex_wreg_i, ex_wdata_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o,
        input  mem_waddr_o, mem_wreg_o, mem_wdata_o,
        input  wb_waddr_o, wb_wreg_o, wb_wdata_o
    );

    // Register file side
    modport slave (
        input  stall_i, flush_i,
        input  ex_waddr_i, ex_wreg_i, ex_wdata_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o,
        output mem_waddr_o, mem_wreg_o, mem_wdata_o,
        output wb_waddr_o, wb_wreg_o, wb_wdata_o
    );
endinterface

// File: rtl/wb_regfile.sv
// EX/MEM and MEM/WB result pipeline, 32-entry register file, forwarding read ports.
module wb_regfile #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NREG = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_regfile_if.slave      bus
);

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic          wreg;
        logic [DW-1:0] wdata;
    } stage_t;

    stage_t        ex_s;
    stage_t        mem_q;
    stage_t        wb_q;
    logic [DW-1:0] regs [NREG];

    assign ex_s = '{waddr: bus.ex_waddr_i, wreg: bus.ex_wreg_i, wdata: bus.ex_wdata_i};

    assign bus.mem_waddr_o = mem_q.waddr;
    assign bus.mem_wreg_o  = mem_q.wreg;
    assign bus.mem_wdata_o = mem_q.wdata;
    assign bus.wb_waddr_o  = wb_q.waddr;
    assign bus.wb_wreg_o   = wb_q.wreg;
    assign bus.wb_wdata_o  = wb_q.wdata;

    // Pipeline registers: flush squashes both, stall freezes EX/MEM and bubbles MEM/WB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (bus.flush_i) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (bus.stall_i) begin
            wb_q  <= '0;
        end else begin
            mem_q <= ex_s;
            wb_q  <= mem_q;
        end
    end

    // Architectural array commit from WB; r0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_q.wreg && (wb_q.waddr != '0)) begin
            regs[wb_q.waddr] <= wb_q.wdata;
        end
    end

    // Youngest in-flight result wins; bubbles never forward
    function automatic logic [DW-1:0] read_port(
        input logic          rst_v,
        input logic          re,
        input logic [AW-1:0] raddr
    );
        logic [DW-1:0] val;
        val = '0;
        if (!rst_v || !re || (raddr == '0)) begin
            val = '0;
        end else if (ex_s.wreg && (ex_s.waddr == raddr)) begin
            val = ex_s.wdata;
        end else if (mem_q.wreg && (mem_q.waddr == raddr)) begin
            val = mem_q.wdata;
        end else if (wb_q.wreg && (wb_q.waddr == raddr)) begin
            val = wb_q.wdata;
        end else begin
            val = regs[raddr];
        end
        return val;
    endfunction

    // Read port 1
    always_comb begin
        bus.rdata1_o = read_port(rst, bus.re1_i, bus.raddr1_i);
    end

    // Read port 2
    always_comb begin
        bus.rdata2_o = read_port(rst, bus.re2_i, bus.raddr2_i);
    end

endmodule
